// File: rtl/ex_stage_mc_pkg.sv
// rtl/ex_stage_mc_pkg.sv - shared field positions, ALU opcode bits and divider FSM encoding
package ex_stage_mc_pkg;

  // Control bits below the four XLEN words and alu_op in to_EX_data
  localparam int TO_EX_CTRL_W  = 13;
  // Control bits below the two XLEN words in to_MEM_data
  localparam int TO_MEM_CTRL_W = 8;

  // Bit positions of the low-order fields of to_EX_data
  localparam int EXF_GR_WE        = 0;
  localparam int EXF_DEST_LO      = 1;
  localparam int EXF_RES_FROM_MEM = 6;
  localparam int EXF_MEM_WE       = 7;
  localparam int EXF_SRC2_IS_IMM  = 8;
  localparam int EXF_SRC1_IS_PC   = 9;
  localparam int EXF_DIV_LO       = 10;
  localparam int EXF_ALU_LO       = 13;

  // div_op[2:0] = {valid, signed, rem_sel}
  localparam int DIV_OP_REM    = 0;
  localparam int DIV_OP_SIGNED = 1;
  localparam int DIV_OP_VALID  = 2;

  // One-hot alu_op bit assignments
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/ex_stage_mc_div_iter.sv
// rtl/ex_stage_mc_div_iter.sv - iterative restoring divider, one quotient bit per cycle
module div_iter
  import ex_stage_mc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic            i_ack,
  input  logic            i_signed,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_done,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  localparam int CW = $clog2(XLEN);

  div_state_e      r_state;
  div_state_e      w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dsr;
  logic [XLEN-1:0] r_dividend;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_dsr_zero;

  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_fits;

  // Magnitudes fed to the unsigned core; signs are reapplied at the output
  assign w_a_neg = i_signed & i_dividend[XLEN-1];
  assign w_b_neg = i_signed & i_divisor[XLEN-1];
  assign w_a_abs = w_a_neg ? -i_dividend : i_dividend;
  assign w_b_abs = w_b_neg ? -i_divisor : i_divisor;

  // Partial remainder shifted left with the next dividend bit; bit XLEN of the
  // difference is the borrow because the partial remainder is always < divisor
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_dsr};
  assign w_fits  = ~w_diff[XLEN];

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= DIV_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; flush returns to IDLE from anywhere
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      DIV_IDLE: if (i_start) w_state_next = DIV_RUN;
      DIV_RUN:  if (r_cnt == '0) w_state_next = DIV_DONE;
      DIV_DONE: if (i_ack) w_state_next = DIV_IDLE;
      default:  w_state_next = DIV_IDLE;
    endcase
    if (i_flush) w_state_next = DIV_IDLE;
  end

  // Operand capture on start, one shift/subtract step per RUN cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dsr      <= '0;
      r_dividend <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dsr_zero <= 1'b0;
    end else if (i_flush) begin
      r_cnt <= '0;
    end else if (r_state == DIV_IDLE && i_start) begin
      r_cnt      <= CW'(XLEN - 1);
      r_rem      <= '0;
      r_quo      <= w_a_abs;
      r_dsr      <= w_b_abs;
      r_dividend <= i_dividend;
      r_neg_q    <= w_a_neg ^ w_b_neg;
      r_neg_r    <= w_a_neg;
      r_dsr_zero <= (i_divisor == '0);
    end else if (r_state == DIV_RUN) begin
      r_quo <= {r_quo[XLEN-2:0], w_fits};
      r_rem <= w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_done = (r_state == DIV_DONE);

  // Divide-by-zero overrides; MIN/-1 falls out of the magnitude path naturally
  assign o_quotient  = r_dsr_zero ? '1 : (r_neg_q ? -r_quo : r_quo);
  assign o_remainder = r_dsr_zero ? r_dividend : (r_neg_r ? -r_rem : r_rem);

endmodule

// File: rtl/ex_stage_mc.sv
// rtl/ex_stage_mc.sv - execute stage with single-cycle ALU and multi-cycle divider
module ex_stage_mc
  import ex_stage_mc_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 12,
  parameter int DIV_EN   = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   ID_to_EX_valid,
  input  logic [4*XLEN+ALU_OP_W+TO_EX_CTRL_W-1:0] to_EX_data,
  output logic                                   EX_allow_in,
  input  logic                                   MEM_allow_in,
  output logic                                   EX_to_MEM_valid,
  output logic [2*XLEN+TO_MEM_CTRL_W-1:0]        to_MEM_data,
  input  logic                                   EX_flush,
  output logic                                   EX_fwd_we,
  output logic [4:0]                             EX_fwd_dest,
  output logic [XLEN-1:0]                        EX_fwd_value,
  output logic                                   EX_fwd_pending
);

  localparam int TO_EX_W = 4*XLEN + ALU_OP_W + TO_EX_CTRL_W;
  localparam int IMM_LO  = EXF_ALU_LO + ALU_OP_W;
  localparam int RKD_LO  = IMM_LO + XLEN;
  localparam int RJ_LO   = RKD_LO + XLEN;
  localparam int PC_LO   = RJ_LO + XLEN;
  localparam int SHW     = $clog2(XLEN);

  logic                r_ex_valid;
  logic [TO_EX_W-1:0]  r_payload;

  logic [XLEN-1:0]     w_pc;
  logic [XLEN-1:0]     w_rj;
  logic [XLEN-1:0]     w_rkd;
  logic [XLEN-1:0]     w_imm;
  logic [ALU_OP_W-1:0] w_alu_op;
  logic                w_div_valid;
  logic                w_div_signed;
  logic                w_rem_sel;
  logic                w_src1_is_pc;
  logic                w_src2_is_imm;
  logic                w_mem_we;
  logic                w_res_from_mem;
  logic [4:0]          w_dest;
  logic                w_gr_we;

  logic [XLEN-1:0]     w_src1;
  logic [XLEN-1:0]     w_src2;
  logic [SHW-1:0]      w_shamt;
  logic [XLEN-1:0]     w_alu_res;
  logic [XLEN-1:0]     w_result;
  logic                w_is_div;
  logic                w_div_done;
  logic [XLEN-1:0]     w_div_q;
  logic [XLEN-1:0]     w_div_r;
  logic                w_ready_go;

  // Payload field extraction
  assign w_pc           = r_payload[PC_LO +: XLEN];
  assign w_rj           = r_payload[RJ_LO +: XLEN];
  assign w_rkd          = r_payload[RKD_LO +: XLEN];
  assign w_imm          = r_payload[IMM_LO +: XLEN];
  assign w_alu_op       = r_payload[EXF_ALU_LO +: ALU_OP_W];
  assign w_div_valid    = r_payload[EXF_DIV_LO + DIV_OP_VALID];
  assign w_div_signed   = r_payload[EXF_DIV_LO + DIV_OP_SIGNED];
  assign w_rem_sel      = r_payload[EXF_DIV_LO + DIV_OP_REM];
  assign w_src1_is_pc   = r_payload[EXF_SRC1_IS_PC];
  assign w_src2_is_imm  = r_payload[EXF_SRC2_IS_IMM];
  assign w_mem_we       = r_payload[EXF_MEM_WE];
  assign w_res_from_mem = r_payload[EXF_RES_FROM_MEM];
  assign w_dest         = r_payload[EXF_DEST_LO +: 5];
  assign w_gr_we        = r_payload[EXF_GR_WE];

  // EX valid bit; flush beats a simultaneous accept
  always_ff @(posedge clk) begin
    if (reset)            r_ex_valid <= 1'b0;
    else if (EX_flush)    r_ex_valid <= 1'b0;
    else if (EX_allow_in) r_ex_valid <= ID_to_EX_valid;
  end

  // Payload register loads only on an accept
  always_ff @(posedge clk) begin
    if (reset)                              r_payload <= '0;
    else if (EX_allow_in && ID_to_EX_valid) r_payload <= to_EX_data;
  end

  assign w_src1  = w_src1_is_pc ? w_pc : w_rj;
  assign w_src2  = w_src2_is_imm ? w_imm : w_rkd;
  assign w_shamt = w_src2[SHW-1:0];

  // One-hot ALU; no op selected yields zero
  always_comb begin
    w_alu_res = '0;
    if (w_alu_op[ALU_ADD])       w_alu_res = w_src1 + w_src2;
    else if (w_alu_op[ALU_SUB])  w_alu_res = w_src1 - w_src2;
    else if (w_alu_op[ALU_SLT])  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(w_src1) < $signed(w_src2))};
    else if (w_alu_op[ALU_SLTU]) w_alu_res = {{(XLEN-1){1'b0}}, (w_src1 < w_src2)};
    else if (w_alu_op[ALU_AND])  w_alu_res = w_src1 & w_src2;
    else if (w_alu_op[ALU_NOR])  w_alu_res = ~(w_src1 | w_src2);
    else if (w_alu_op[ALU_OR])   w_alu_res = w_src1 | w_src2;
    else if (w_alu_op[ALU_XOR])  w_alu_res = w_src1 ^ w_src2;
    else if (w_alu_op[ALU_SLL])  w_alu_res = w_src1 << w_shamt;
    else if (w_alu_op[ALU_SRL])  w_alu_res = w_src1 >> w_shamt;
    else if (w_alu_op[ALU_SRA])  w_alu_res = $unsigned($signed(w_src1) >>> w_shamt);
    else if (w_alu_op[ALU_LUI])  w_alu_res = w_src2;
  end

  generate
    if (DIV_EN != 0) begin : g_div
      div_iter #(.XLEN(XLEN)) u_div (
        .clk         (clk),
        .reset       (reset),
        .i_start     (r_ex_valid & w_div_valid),
        .i_flush     (EX_flush),
        .i_ack       (MEM_allow_in),
        .i_signed    (w_div_signed),
        .i_dividend  (w_rj),
        .i_divisor   (w_rkd),
        .o_done      (w_div_done),
        .o_quotient  (w_div_q),
        .o_remainder (w_div_r)
      );
      assign w_is_div = w_div_valid;
    end else begin : g_no_div
      assign w_div_done = 1'b0;
      assign w_div_q    = '0;
      assign w_div_r    = '0;
      assign w_is_div   = 1'b0;
    end
  endgenerate

  // Result select; a divide without a divider completes immediately with zero
  always_comb begin
    w_result = w_alu_res;
    if (w_div_valid) w_result = w_is_div ? (w_rem_sel ? w_div_r : w_div_q) : '0;
  end

  assign w_ready_go      = w_is_div ? w_div_done : 1'b1;
  assign EX_allow_in     = ~r_ex_valid | (w_ready_go & MEM_allow_in);
  assign EX_to_MEM_valid = r_ex_valid & w_ready_go & ~EX_flush;
  assign to_MEM_data     = {w_result, w_rkd, w_mem_we, w_res_from_mem, w_dest, w_gr_we};

  assign EX_fwd_we      = r_ex_valid & w_gr_we & (w_dest != 5'd0);
  assign EX_fwd_dest    = w_dest;
  assign EX_fwd_value   = w_result;
  assign EX_fwd_pending = EX_fwd_we & (w_res_from_mem | ~w_ready_go);

endmodule

// File: tb/tb_ex_stage_mc.sv
// tb/tb_ex_stage_mc.sv - self-checking bench for ex_stage_mc
module tb_ex_stage_mc;

  localparam int XLEN  = 32;
  localparam int AW    = 12;
  localparam int IN_W  = 4*XLEN + AW + 13;
  localparam int OUT_W = 2*XLEN + 8;
  localparam int DIV_LAT = XLEN + 2;

  // op codes: 0..11 ALU one-hot index, 12 DIV, 13 MOD, 14 DIVU, 15 MODU
  typedef struct {
    int          op;
    logic [31:0] pc;
    logic [31:0] rj;
    logic [31:0] rkd;
    logic [31:0] imm;
    logic        s1pc;
    logic        s2imm;
    logic        mem_we;
    logic        rfm;
    logic [4:0]  dest;
    logic        gr_we;
  } instr_t;

  typedef struct {
    string       name;
    instr_t      ins;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             ID_to_EX_valid;
  logic [IN_W-1:0]  to_EX_data;
  logic             EX_allow_in;
  logic             MEM_allow_in;
  logic             EX_to_MEM_valid;
  logic [OUT_W-1:0] to_MEM_data;
  logic             EX_flush;
  logic             EX_fwd_we;
  logic [4:0]       EX_fwd_dest;
  logic [31:0]      EX_fwd_value;
  logic             EX_fwd_pending;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  ex_stage_mc #(.XLEN(XLEN), .ALU_OP_W(AW), .DIV_EN(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .ID_to_EX_valid (ID_to_EX_valid),
    .to_EX_data     (to_EX_data),
    .EX_allow_in    (EX_allow_in),
    .MEM_allow_in   (MEM_allow_in),
    .EX_to_MEM_valid(EX_to_MEM_valid),
    .to_MEM_data    (to_MEM_data),
    .EX_flush       (EX_flush),
    .EX_fwd_we      (EX_fwd_we),
    .EX_fwd_dest    (EX_fwd_dest),
    .EX_fwd_value   (EX_fwd_value),
    .EX_fwd_pending (EX_fwd_pending)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic instr_t mk(input int op, input logic [31:0] pc, input logic [31:0] rj,
                                input logic [31:0] rkd, input logic [31:0] imm, input logic s1pc,
                                input logic s2imm, input logic rfm, input logic [4:0] dest);
    instr_t i;
    i.op = op; i.pc = pc; i.rj = rj; i.rkd = rkd; i.imm = imm;
    i.s1pc = s1pc; i.s2imm = s2imm; i.mem_we = 1'b0; i.rfm = rfm;
    i.dest = dest; i.gr_we = 1'b1;
    return i;
  endfunction

  function automatic logic [IN_W-1:0] encode(input instr_t i);
    logic [AW-1:0] aop;
    logic [2:0]    dop;
    aop = '0;
    dop = '0;
    if (i.op < 12) aop[i.op] = 1'b1;
    else dop = {1'b1, (i.op == 12 || i.op == 13), (i.op == 13 || i.op == 15)};
    return {i.pc, i.rj, i.rkd, i.imm, aop, dop, i.s1pc, i.s2imm, i.mem_we, i.rfm, i.dest, i.gr_we};
  endfunction

  // Architectural reference: plain operators plus the two defined corner cases
  function automatic logic [31:0] ref_result(input instr_t i);
    logic [31:0] a, b, q, r;
    logic        sgn;
    a = i.s1pc ? i.pc : i.rj;
    b = i.s2imm ? i.imm : i.rkd;
    case (i.op)
      0:  return a + b;
      1:  return a - b;
      2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return a << b[4:0];
      9:  return a >> b[4:0];
      10: return $signed(a) >>> b[4:0];
      11: return b;
      default: begin
        sgn = (i.op == 12 || i.op == 13);
        if (i.rkd == 32'd0) begin
          q = 32'hFFFF_FFFF; r = i.rj;
        end else if (sgn && i.rj == 32'h8000_0000 && i.rkd == 32'hFFFF_FFFF) begin
          q = 32'h8000_0000; r = 32'd0;
        end else if (sgn) begin
          q = $signed(i.rj) / $signed(i.rkd);
          r = $signed(i.rj) % $signed(i.rkd);
        end else begin
          q = i.rj / i.rkd;
          r = i.rj % i.rkd;
        end
        return (i.op == 13 || i.op == 15) ? r : q;
      end
    endcase
  endfunction

  task automatic add_vec(input string nm, input instr_t ins, input logic [31:0] expv, input int lat);
    vec_t v;
    v.name = nm; v.ins = ins; v.exp_res = expv; v.exp_lat = lat;
    vecs.push_back(v);
  endtask

  // Issue one instruction into an idle stage and check its handoff
  task automatic issue_check(input string nm, input instr_t ins, input logic [31:0] expv, input int explat);
    int   lat;
    bit   stall_ok;
    logic exp_fwd;
    exp_fwd = ins.gr_we && (ins.dest != 5'd0);
    @(negedge clk);
    EX_flush = 1'b0; MEM_allow_in = 1'b1; ID_to_EX_valid = 1'b1; to_EX_data = encode(ins);
    #1;
    chk({nm, " allow_in"}, EX_allow_in, 1);
    @(negedge clk);
    ID_to_EX_valid = 1'b0;
    #1;
    lat = 1;
    stall_ok = 1'b1;
    while (!EX_to_MEM_valid && lat < 100) begin
      if (EX_allow_in !== 1'b0 || EX_fwd_pending !== exp_fwd) stall_ok = 1'b0;
      @(negedge clk);
      #1;
      lat++;
    end
    chk({nm, " latency"}, lat, explat);
    if (explat > 1) chk({nm, " stall"}, stall_ok, 1);
    chk({nm, " to_MEM_data"}, to_MEM_data, {expv, ins.rkd, ins.mem_we, ins.rfm, ins.dest, ins.gr_we});
    chk({nm, " fwd"}, {EX_fwd_we, EX_fwd_dest, EX_fwd_pending}, {exp_fwd, ins.dest, exp_fwd & ins.rfm});
    chk({nm, " fwd_value"}, EX_fwd_value, expv);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t ins;
    logic [OUT_W-1:0] held;
    int   lat;
    bit   ok;

    // Directed vectors
    add_vec("ADD",       mk(0,  0, 5, 7, 0, 0, 0, 0, 3), 32'd12, 1);
    add_vec("SUB",       mk(1,  0, 3, 10, 0, 0, 0, 0, 6), 32'hFFFF_FFF9, 1);
    add_vec("SLT",       mk(2,  0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 7), 32'd1, 1);
    add_vec("SLTU",      mk(3,  0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 7), 32'd0, 1);
    add_vec("NOR",       mk(5,  0, 32'hF0F0_F0F0, 32'h0F0F_0000, 0, 0, 0, 0, 8), 32'h0000_0F0F, 1);
    add_vec("SRA_IMM",   mk(10, 0, 32'h8000_0000, 0, 4, 0, 1, 0, 9), 32'hF800_0000, 1);
    add_vec("PC_IMM",    mk(0,  32'h1000, 0, 0, 4, 1, 1, 0, 1), 32'h0000_1004, 1);
    add_vec("LUI",       mk(11, 0, 0, 0, 32'h1234_5000, 0, 1, 0, 2), 32'h1234_5000, 1);
    add_vec("LOAD_ADDR", mk(0,  0, 32'h100, 0, 8, 0, 1, 1, 5), 32'h108, 1);
    add_vec("DIV_M7_2",  mk(12, 0, 32'hFFFF_FFF9, 2, 0, 0, 0, 0, 4), 32'hFFFF_FFFD, DIV_LAT);
    add_vec("MOD_M7_2",  mk(13, 0, 32'hFFFF_FFF9, 2, 0, 0, 0, 0, 4), 32'hFFFF_FFFF, DIV_LAT);
    add_vec("DIVU_BY0",  mk(14, 0, 100, 0, 0, 0, 0, 0, 10), 32'hFFFF_FFFF, DIV_LAT);
    add_vec("MODU_BY0",  mk(15, 0, 100, 0, 0, 0, 0, 0, 10), 32'd100, DIV_LAT);
    add_vec("DIV_OVF",   mk(12, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 11), 32'h8000_0000, DIV_LAT);
    add_vec("MOD_OVF",   mk(13, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 11), 32'd0, DIV_LAT);
    add_vec("MOD_7_M2",  mk(13, 0, 7, 32'hFFFF_FFFE, 0, 0, 0, 0, 0), 32'd1, DIV_LAT);

    // Reset held three cycles
    reset = 1'b1; ID_to_EX_valid = 1'b0; to_EX_data = '0; MEM_allow_in = 1'b1; EX_flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset allow_in", EX_allow_in, 1);
    chk("reset to_MEM_valid", EX_to_MEM_valid, 0);
    chk("reset fwd_we", EX_fwd_we, 0);
    chk("reset fwd_pending", EX_fwd_pending, 0);
    chk("reset to_MEM_data", to_MEM_data, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < vecs.size(); k++)
      issue_check(vecs[k].name, vecs[k].ins, vecs[k].exp_res, vecs[k].exp_lat);

    // Flush in RUN cycle 10, then an ADD and a full-length divide
    ins = mk(12, 0, 1000, 7, 0, 0, 0, 0, 2);
    @(negedge clk);
    MEM_allow_in = 1'b1; ID_to_EX_valid = 1'b1; to_EX_data = encode(ins);
    @(negedge clk);
    ID_to_EX_valid = 1'b0;
    repeat (10) @(negedge clk);
    EX_flush = 1'b1;
    #1;
    chk("flush cycle to_MEM_valid", EX_to_MEM_valid, 0);
    chk("flush cycle pending", EX_fwd_pending, 1);
    @(negedge clk);
    EX_flush = 1'b0;
    #1;
    chk("post flush allow_in", EX_allow_in, 1);
    chk("post flush to_MEM_valid", EX_to_MEM_valid, 0);
    chk("post flush fwd_we", EX_fwd_we, 0);
    issue_check("ADD after flush", mk(0, 0, 20, 22, 0, 0, 0, 0, 3), 32'd42, 1);
    issue_check("DIV after flush", ins, 32'd142, DIV_LAT);

    // MEM stall in DONE for five cycles, then handoff with a back-to-back divide
    @(negedge clk);
    MEM_allow_in = 1'b0; ID_to_EX_valid = 1'b1; to_EX_data = encode(ins);
    @(negedge clk);
    ID_to_EX_valid = 1'b0;
    #1;
    lat = 1;
    while (!EX_to_MEM_valid && lat < 100) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk("stall div latency", lat, DIV_LAT);
    held = to_MEM_data;
    chk("stall div data", held, {32'd142, 32'd7, 1'b0, 1'b0, 5'd2, 1'b1});
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (to_MEM_data !== held || EX_allow_in !== 1'b0 || EX_to_MEM_valid !== 1'b1) ok = 1'b0;
    end
    chk("stall hold stable", ok, 1);
    ins = mk(13, 0, 1000, 7, 0, 0, 0, 0, 2);
    MEM_allow_in = 1'b1; ID_to_EX_valid = 1'b1; to_EX_data = encode(ins);
    #1;
    chk("release allow_in", EX_allow_in, 1);
    chk("release to_MEM_valid", EX_to_MEM_valid, 1);
    @(negedge clk);
    ID_to_EX_valid = 1'b0;
    #1;
    lat = 1;
    while (!EX_to_MEM_valid && lat < 100) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk("back2back latency", lat, DIV_LAT);
    chk("back2back data", to_MEM_data, {32'd6, 32'd7, 1'b0, 1'b0, 5'd2, 1'b1});

    // Flush in the same cycle as a new instruction
    @(negedge clk);
    ID_to_EX_valid = 1'b1; EX_flush = 1'b1; to_EX_data = encode(mk(0, 0, 1, 1, 0, 0, 0, 0, 3));
    @(negedge clk);
    ID_to_EX_valid = 1'b0; EX_flush = 1'b0;
    #1;
    chk("flush+accept to_MEM_valid", EX_to_MEM_valid, 0);
    chk("flush+accept fwd_we", EX_fwd_we, 0);
    chk("flush+accept allow_in", EX_allow_in, 1);

    // Randomized instructions against the reference model
    for (int n = 0; n < 40; n++) begin
      int sel;
      ins.op     = $urandom_range(0, 15);
      ins.pc     = $urandom;
      ins.rj     = $urandom;
      ins.rkd    = $urandom;
      ins.imm    = $urandom;
      ins.s1pc   = $urandom_range(0, 1);
      ins.s2imm  = $urandom_range(0, 1);
      ins.mem_we = $urandom_range(0, 1);
      ins.rfm    = $urandom_range(0, 1);
      ins.dest   = 5'($urandom_range(0, 31));
      ins.gr_we  = $urandom_range(0, 1);
      sel = $urandom_range(0, 7);
      if (sel == 0) ins.rkd = 32'd0;
      else if (sel == 1) begin ins.rj = 32'h8000_0000; ins.rkd = 32'hFFFF_FFFF; end
      else if (sel == 2) ins.rkd = 32'($urandom_range(1, 15));
      issue_check($sformatf("rand%0d op%0d", n, ins.op), ins, ref_result(ins),
                  (ins.op >= 12) ? DIV_LAT : 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
